lsu_data_mem: RTL

Parametrised load/store data memory for the RISC-V datapath. It replaces the fixed 64-word, word-only, combinational-read data memory.
- Adds byte, halfword and word accesses with sign/zero extension and byte-lane writes.
- Adds configurable depth and wait states.
- Uses a valid/ready request and response handshake.
- Flags misaligned and out-of-range accesses instead of aliasing them.
It sits between the ALU address output and the write-back mux, and serves as the memory stage of the multi-cycle core.

---
 rtl/lsu_data_mem.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_data_mem.sv
//==============================================================================
// Module      : lsu_data_mem
// Description : Load/store data memory for the memory stage of the multi-cycle
//               RISC-V core. Byte/half/word accesses with sign or zero
//               extension, byte-lane stores, programmable wait states and a
//               valid/ready request/response handshake. Misaligned,
//               illegal-size and out-of-range accesses return an error
//               response and never touch the array.
//
// Ports       : clk           rising-edge clock
//               reset         synchronous, active-low reset
//               req_valid     request present (held by requester until taken)
//               req_ready     high in IDLE: request accepted this cycle
//               req_we        1 = store, 0 = load
//               req_size      00 byte, 01 half, 10 word, 11 illegal
//               req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//               req_addr      byte address (little-endian)
//               req_wdata     right-aligned store data
//               rsp_valid     response available, held until rsp_ready
//               rsp_ready     consumer takes the response
//               rsp_rdata     extended load data; 0 for stores and errors
//               rsp_err       misaligned / out of range / illegal size
//               busy          state is not IDLE
//               err_count     saturating error-response counter (only when
//                             LSU_DMEM_ERR_CNT_EN is defined)
//
// Options     : `define LSU_DMEM_ERR_CNT_EN adds the err_count output.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lsu_data_mem #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
`ifdef LSU_DMEM_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT  = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Registered request
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_cnt;

    // Response registers
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_mem [DEPTH];

    //--------------------------------------------------------------------------
    // Access source. RESP is entered straight from IDLE when there are no wait
    // states, and in that case the request has not been registered yet, so
    // the live inputs are used; otherwise the registered copy is used.
    //--------------------------------------------------------------------------
    logic              w_use_in;
    logic              w_we;
    logic [1:0]        w_size;
    logic              w_unsigned;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;

    assign w_use_in   = (r_state == ST_IDLE);
    assign w_we       = w_use_in ? req_we       : r_we;
    assign w_size     = w_use_in ? req_size     : r_size;
    assign w_unsigned = w_use_in ? req_unsigned : r_unsigned;
    assign w_addr     = w_use_in ? req_addr     : r_addr;
    assign w_wdata    = w_use_in ? req_wdata    : r_wdata;

    //--------------------------------------------------------------------------
    // Address decode and error detection
    //--------------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic [ADDR_W-1:0]  w_hi;
    logic               w_oor;
    logic               w_misalign;
    logic               w_err;

    assign w_idx  = w_addr[c_IDX_W+1:2];
    assign w_lane = w_addr[1:0];
    // Any address bit above the array range is an error; no aliasing.
    assign w_hi   = w_addr >> (c_IDX_W + 2);
    assign w_oor  = |w_hi;

    always_comb begin
        w_misalign = 1'b0;
        case (w_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_lane[0];
            2'b10:   w_misalign = |w_lane;
            default: w_misalign = 1'b1;  // illegal size
        endcase
    end

    assign w_err = w_misalign | w_oor;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = (c_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The access itself (store commit / load sample) happens on RESP entry
    logic w_enter_resp;
    logic w_commit;

    assign w_enter_resp = reset && (r_state != ST_RESP) && (w_next_state == ST_RESP);
    assign w_commit     = w_enter_resp && w_we && !w_err;

    //--------------------------------------------------------------------------
    // Store lane enables and lane-replicated write data
    //--------------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_wdata;
        case (w_size)
            2'b00: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = w_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = w_wdata;
            end
        endcase
    end

    // Array is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Load lane select and extension
    //--------------------------------------------------------------------------
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (w_size)
            2'b00:   w_load = {{24{w_byte[7]  & ~w_unsigned}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~w_unsigned}}, w_half};
            default: w_load = w_word;
        endcase
    end

    //--------------------------------------------------------------------------
    // Request capture, wait counter and response registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_cnt      <= c_WAIT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_err       <= w_err;
                r_rdata     <= (w_we || w_err) ? 32'd0 : w_load;
            end else if (r_state == ST_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

`ifdef LSU_DMEM_ERR_CNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_count <= 8'd0;
        end else if (r_rsp_valid && rsp_ready && r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire
